game_button_conditioner: RTL and testbench
==========================================

Name: game_button_conditioner

Overview:
Parametrised N-channel button front end that replaces the fixed 4-button debounce/edge block. Per channel it does four things:
- 2-FF synchronisation and optional polarity inversion.
- Tick-based debounce.
- Press and release one-shots.
- Long-press detection and optional auto-repeat while held.

It sits between the board button pins and the game FSM. Any channel can drive start, restart or play logic.

Parameters:
N_BTN, 4, number of button channels
BTN_ACTIVE_LOW, 0, 1 = raw pin is low when pressed (inverted after synchroniser)
DEBOUNCE_MS, 20, consecutive differing ticks required to accept a new level (>=1)
LONG_MS, 1000, ticks of stable press before o_long fires (>DEBOUNCE_MS, <2^CNT_W)
REPEAT_MS, 150, tick period of o_repeat once long-press reached (>=1, <2^CNT_W)
CNT_W, 12, width of per-channel hold/repeat counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_tick  in  1  1 ms enable pulse, one clk wide
i_btn  in  N_BTN  raw button pins, asynchronous
i_repeat_en  in  N_BTN  per-channel auto-repeat enable
o_level  out  N_BTN  debounced pressed level
o_press  out  N_BTN  one-clk pulse on debounced press
o_release  out  N_BTN  one-clk pulse on debounced release
o_long  out  N_BTN  one-clk pulse when hold reaches LONG_MS
o_repeat  out  N_BTN  one-clk pulse every REPEAT_MS ticks after o_long, if repeat enabled
o_any_press  out  1  OR of o_press

Behaviour:
- Reset:
  - Asynchronous, active-low; all flops are cleared while rst_n=0.
  - Synchroniser, stable level, debounce/hold/repeat counters and all outputs reset to 0; FSM resets to IDLE.
  - Deassertion with a button held produces a normal press after sync + debounce.
- Sync: i_btn passes through two flops, then XOR with BTN_ACTIVE_LOW, giving btn_s. This is 2 clk of latency.
- Debounce (per channel, evaluated only on i_tick=1):
  - If btn_s != stable and deb_cnt == DEBOUNCE_MS-1: stable <= btn_s, deb_cnt <= 0.
  - Else if btn_s != stable: deb_cnt++.
  - Else: deb_cnt <= 0.
  - Stable therefore changes on the DEBOUNCE_MS-th consecutive differing tick.
  - Any matching tick restarts the count.
- Output level: o_level = stable, registered.
- Edges:
  - Registered compare of stable vs its previous value.
  - o_press or o_release is high for exactly one clk, the cycle after stable changes.
- Per-channel FSM:
  - IDLE → PRESSED on stable rise; hold_cnt <= 0.
  - PRESSED: on each tick with stable=1, hold_cnt++. When hold_cnt reaches LONG_MS-1 on a tick: pulse o_long next clk, go to HELD, rep_cnt <= 0.
  - HELD with i_repeat_en=1: on each tick rep_cnt++. When rep_cnt reaches REPEAT_MS-1: pulse o_repeat, rep_cnt <= 0.
  - HELD with i_repeat_en=0: rep_cnt is held at 0 and no o_repeat is produced.
  - Any state → IDLE on stable fall; counters cleared; o_release pulses.
- Priority on the same tick:
  - Stable fall beats the long/repeat threshold: no o_long or o_repeat, only o_release.
  - o_long and the first o_repeat can never coincide; the first repeat comes REPEAT_MS ticks after o_long.
- Counters saturate; no wrap. hold_cnt stops counting in HELD.
- i_repeat_en going high mid-HELD: rep_cnt starts from 0 at that tick.
- No tick: a design with no i_tick never changes stable; edges and FSM stay idle.
- Channels are fully independent; simultaneous events on multiple channels all pulse in the same clk.
- Output timing: all one-shot outputs are registered and at most 1 clk wide per event. o_any_press is registered with o_press.

Test Plan:
Bench config: N_BTN=4, DEBOUNCE_MS=4, LONG_MS=10, REPEAT_MS=3, i_tick every 8 clk.
- Reset: hold rst_n=0 with i_btn=4'b1111 → all outputs 0. After release, o_press=4'b1111 exactly once after the 4th tick plus 1 clk.
- Bounce: ch0 toggles 1,0,1 on successive ticks, then steady 1 → no o_press until 4 consecutive steady ticks, then a single 1-clk pulse. Release after 4 ticks low → single o_release.
- Long press with repeat: ch2 held 30 ticks, i_repeat_en[2]=1 → o_press once, o_long at press+10 ticks, o_repeat at +13, +16, +19 … ticks. Release gives o_release and no further repeats.
- Repeat disabled: same stimulus with i_repeat_en=0 → o_long once, zero o_repeat.
- Simultaneous fall vs threshold: debounced release lands on the tick where hold_cnt=9 → o_release only, no o_long. Also check: ch1 and ch3 pressed in the same clk → both o_press bits in the same clk and o_any_press=1 for one clk.
- Active-low build: BTN_ACTIVE_LOW=1, pins idle 1, pull ch0 low → o_level[0]=1 and o_press[0] pulses. Assert rst_n=0 mid-HELD → outputs clear immediately and no o_release is produced.

Source files
------------

// File: rtl/game_button_conditioner.sv
// ----------------------------------------------------------------------------
// game_button_conditioner
//
// N-channel button front end placed between the board button pins and the
// game FSM. Each channel is conditioned independently:
//   1. 2-FF synchroniser, then optional polarity inversion (active-low pins).
//   2. Tick-based debounce: a new level is accepted only after DEBOUNCE_MS
//      consecutive i_tick samples that all differ from the current level.
//   3. Registered press / release one-shots from the debounced level.
//   4. Hold tracking FSM (IDLE / PRESSED / HELD) that pulses o_long once the
//      press has lasted LONG_MS ticks, and then o_repeat every REPEAT_MS
//      ticks while the channel's auto-repeat enable is high.
//
// Parameters:
//   N_BTN          number of button channels
//   BTN_ACTIVE_LOW 1 = raw pin reads low when pressed
//   DEBOUNCE_MS    consecutive differing ticks needed to accept a level (>=1)
//   LONG_MS        ticks of stable press before o_long (>DEBOUNCE_MS, <2^CNT_W)
//   REPEAT_MS      o_repeat period in ticks once held (>=1, <2^CNT_W)
//   CNT_W          width of the per-channel hold / repeat counters
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset, clears every flop
//   i_tick       1 ms enable pulse, one clk wide
//   i_btn        raw button pins (asynchronous)
//   i_repeat_en  per-channel auto-repeat enable
//   o_level      debounced pressed level
//   o_press      one-clk pulse on debounced press
//   o_release    one-clk pulse on debounced release
//   o_long       one-clk pulse when the hold reaches LONG_MS ticks
//   o_repeat     one-clk pulse every REPEAT_MS ticks after o_long (if enabled)
//   o_any_press  OR of o_press, aligned with it
// ----------------------------------------------------------------------------
module game_button_conditioner #(
    parameter int N_BTN          = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b0,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter int REPEAT_MS      = 150,
    parameter int CNT_W          = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [N_BTN-1:0] i_repeat_en,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_any_press
);

    // The debounce counter only ever holds 0 .. DEBOUNCE_MS-1.
    localparam int DEB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser and polarity
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] btn_s;

    // Inversion sits after the synchroniser so both flops see raw pin levels.
    assign btn_s = sync2_q ^ {N_BTN{BTN_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Debounce state
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] stable_q;
    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] stable_prev_q;
    logic [DEB_W-1:0] deb_cnt_q [N_BTN];
    logic [DEB_W-1:0] deb_cnt_d [N_BTN];

    // ------------------------------------------------------------------
    // Hold / repeat FSM state
    // ------------------------------------------------------------------
    state_e           state_q    [N_BTN];
    state_e           state_d    [N_BTN];
    logic [CNT_W-1:0] hold_cnt_q [N_BTN];
    logic [CNT_W-1:0] hold_cnt_d [N_BTN];
    logic [CNT_W-1:0] rep_cnt_q  [N_BTN];
    logic [CNT_W-1:0] rep_cnt_d  [N_BTN];

    // ------------------------------------------------------------------
    // Output pulse registers
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] o_press_d;
    logic [N_BTN-1:0] o_press_q;
    logic [N_BTN-1:0] o_release_d;
    logic [N_BTN-1:0] o_release_q;
    logic [N_BTN-1:0] o_long_d;
    logic [N_BTN-1:0] o_long_q;
    logic [N_BTN-1:0] o_repeat_d;
    logic [N_BTN-1:0] o_repeat_q;
    logic             o_any_press_d;
    logic             o_any_press_q;

    // ------------------------------------------------------------------
    // Debounce next-state
    // A level change is accepted on the DEBOUNCE_MS-th consecutive
    // differing tick; any tick that matches the current level restarts
    // the count. Without ticks nothing here moves.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (i_tick) begin
                if (btn_s[i] != stable_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        stable_d[i]  = btn_s[i];
                        deb_cnt_d[i] = '0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d[i] = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge one-shots: compare the debounced level with its previous value.
    // ------------------------------------------------------------------
    always_comb begin
        o_press_d     = stable_q & ~stable_prev_q;
        o_release_d   = ~stable_q & stable_prev_q;
        o_any_press_d = |o_press_d;
    end

    // ------------------------------------------------------------------
    // FSM next-state and counters
    // The FSM looks at stable_d (this tick's debounce result) rather than
    // stable_q, so a release that lands on the same tick as the long or
    // repeat threshold wins and suppresses the pulse.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (!stable_d[i]) begin
                state_d[i]    = ST_IDLE;
                hold_cnt_d[i] = '0;
                rep_cnt_d[i]  = '0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        state_d[i]    = ST_PRESSED;
                        hold_cnt_d[i] = '0;
                        rep_cnt_d[i]  = '0;
                    end
                    ST_PRESSED: begin
                        if (i_tick) begin
                            if (hold_cnt_q[i] == HOLD_LAST) begin
                                // hold_cnt parks at HOLD_LAST while HELD.
                                state_d[i]   = ST_HELD;
                                rep_cnt_d[i] = '0;
                            end else begin
                                hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end
                    ST_HELD: begin
                        // Disabled repeat pins rep_cnt at 0, so enabling it
                        // mid-hold starts a full period from that tick.
                        if (!i_repeat_en[i]) begin
                            rep_cnt_d[i] = '0;
                        end else if (i_tick) begin
                            if (rep_cnt_q[i] == REP_LAST) begin
                                rep_cnt_d[i] = '0;
                            end else begin
                                rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                        rep_cnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs: threshold pulses, registered on the tick that hits them.
    // ------------------------------------------------------------------
    always_comb begin
        o_long_d   = '0;
        o_repeat_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            o_long_d[i]   = (state_q[i] == ST_PRESSED) && stable_d[i] && i_tick
                            && (hold_cnt_q[i] == HOLD_LAST);
            o_repeat_d[i] = (state_q[i] == ST_HELD) && stable_d[i] && i_tick
                            && i_repeat_en[i] && (rep_cnt_q[i] == REP_LAST);
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays are ordinary flops, not a RAM, so
            // they are cleared by reset like any other state.
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]    <= ST_IDLE;
                hold_cnt_q[i] <= '0;
                rep_cnt_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser, debounce and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i] <= '0;
            end
            o_press_q     <= '0;
            o_release_q   <= '0;
            o_long_q      <= '0;
            o_repeat_q    <= '0;
            o_any_press_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its neighbours; blocking would collapse the
            // synchroniser stages into one.
            sync1_q       <= i_btn;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            deb_cnt_q     <= deb_cnt_d;
            o_press_q     <= o_press_d;
            o_release_q   <= o_release_d;
            o_long_q      <= o_long_d;
            o_repeat_q    <= o_repeat_d;
            o_any_press_q <= o_any_press_d;
        end
    end

    assign o_level     = stable_q;
    assign o_press     = o_press_q;
    assign o_release   = o_release_q;
    assign o_long      = o_long_q;
    assign o_repeat    = o_repeat_q;
    assign o_any_press = o_any_press_q;

endmodule

// File: tb/tb_game_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_game_button_conditioner
//
// Two instances: dut (active-high pins) carries most scenarios and is watched
// by a pulse scoreboard; dut_b (active-low pins) gets hand-written checks.
// Config: N_BTN=4, DEBOUNCE_MS=4, LONG_MS=10, REPEAT_MS=3, i_tick every 8 clk.
//
// Event timing used for expectations (tick k = tick edge, phase = clk edges
// since that tick edge, sampled on the falling edge):
//   pin changes just after tick k      -> stable changes on tick k+4
//   o_long / o_repeat                  -> tick of threshold, phase 1
//   o_press / o_release / o_any_press  -> tick of stable change, phase 2
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_game_button_conditioner;

    localparam int N = 4;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT, EV_ANY} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       ch;
        int       tk;
        int       ph;
    } ev_t;

    // One vector: which channel is held, for how many ticks, with repeat
    // enabled or not, and what the outputs must do as a result.
    typedef struct {
        int ch;
        int hold;
        bit rep_en;
        bit exp_long;
        int exp_nrep;
    } row_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_tick;
    logic [N-1:0] i_btn;
    logic [N-1:0] i_repeat_en;
    logic [N-1:0] o_level, o_press, o_release, o_long, o_repeat;
    logic         o_any_press;

    logic         rst_n_b;
    logic [N-1:0] btn_b;
    logic [N-1:0] rep_en_b;
    logic [N-1:0] o_level_b, o_press_b, o_release_b, o_long_b, o_repeat_b;
    logic         o_any_press_b;

    int  tick_no = 0;
    int  phase   = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  b_press_cnt   = 0;
    int  b_release_cnt = 0;
    ev_t exp_q[$];
    row_t rows[7];

    game_button_conditioner #(
        .N_BTN(N), .BTN_ACTIVE_LOW(1'b0), .DEBOUNCE_MS(4),
        .LONG_MS(10), .REPEAT_MS(3), .CNT_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_btn(i_btn),
        .i_repeat_en(i_repeat_en), .o_level(o_level), .o_press(o_press),
        .o_release(o_release), .o_long(o_long), .o_repeat(o_repeat),
        .o_any_press(o_any_press)
    );

    game_button_conditioner #(
        .N_BTN(N), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_MS(4),
        .LONG_MS(10), .REPEAT_MS(3), .CNT_W(12)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .i_tick(i_tick), .i_btn(btn_b),
        .i_repeat_en(rep_en_b), .o_level(o_level_b), .o_press(o_press_b),
        .o_release(o_release_b), .o_long(o_long_b), .o_repeat(o_repeat_b),
        .o_any_press(o_any_press_b)
    );

    always #5 clk = ~clk;

    // Tick generator: one clk-wide pulse every 8 clocks, driven on the
    // falling edge.
    initial begin
        int div;
        div    = 0;
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            div    = (div == 7) ? 0 : div + 1;
            i_tick = (div == 7);
        end
    end

    // Tick / phase bookkeeping for the scoreboard.
    always @(posedge clk) begin
        if (i_tick) begin
            tick_no <= tick_no + 1;
            phase   <= 1;
        end else begin
            phase <= phase + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tick %0d", tick_no);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_e k, input int ch, input int tk, input int ph);
        ev_t e;
        e.kind = k;
        e.ch   = ch;
        e.tk   = tk;
        e.ph   = ph;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k, input int ch);
        int idx;
        idx = -1;
        n_checks++;
        foreach (exp_q[j]) begin
            if (idx < 0 && exp_q[j].kind == k && exp_q[j].ch == ch &&
                exp_q[j].tk == tick_no && exp_q[j].ph == phase) begin
                idx = j;
            end
        end
        if (idx >= 0) begin
            exp_q.delete(idx);
        end else begin
            n_fail++;
            $display("FAIL sb_%s ch%0d: pulse at tick %0d phase %0d, none expected there (%0d pending)",
                     k.name(), ch, tick_no, phase, exp_q.size());
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected pulses missing, first %s ch%0d at tick %0d phase %0d",
                     name, exp_q.size(), exp_q[0].kind.name(), exp_q[0].ch,
                     exp_q[0].tk, exp_q[0].ph);
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor on dut, counters on dut_b.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (o_press[c])   observe(EV_PRESS, c);
            if (o_release[c]) observe(EV_RELEASE, c);
            if (o_long[c])    observe(EV_LONG, c);
            if (o_repeat[c])  observe(EV_REPEAT, c);
        end
        if (o_any_press) observe(EV_ANY, 0);
    end

    always @(negedge clk) begin
        if (|o_press_b)   b_press_cnt   <= b_press_cnt + 1;
        if (|o_release_b) b_release_cnt <= b_release_cnt + 1;
    end

    // Returns on the falling edge just after the next tick edge (phase 1).
    task automatic at_tick();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!i_tick && guard < 16);
        if (!i_tick) begin
            $display("FAIL tick_wait: no i_tick within 16 clk");
            $fatal(1, "tick wait expired");
        end
        @(negedge clk);
    endtask

    task automatic run_row(input int idx, input row_t r);
        int k, p, f;
        at_tick();
        k = tick_no;
        p = k + 4;
        f = k + r.hold + 4;
        push(EV_PRESS, r.ch, p, 2);
        push(EV_ANY, 0, p, 2);
        if (r.exp_long) push(EV_LONG, r.ch, p + 10, 1);
        for (int j = 0; j < r.exp_nrep; j++) push(EV_REPEAT, r.ch, p + 13 + 3 * j, 1);
        push(EV_RELEASE, r.ch, f, 2);
        i_repeat_en[r.ch] = r.rep_en;
        i_btn[r.ch]       = 1'b1;
        for (int t = 1; t <= r.hold; t++) begin
            at_tick();
            if (t == 5) check($sformatf("row%0d_level_held", idx), 32'(o_level), 32'(1) << r.ch);
        end
        i_btn[r.ch] = 1'b0;
        repeat (8) at_tick();
        check($sformatf("row%0d_level_released", idx), 32'(o_level), 32'd0);
        check_drained($sformatf("row%0d_events", idx));
        i_repeat_en = '0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int k;
        //          ch hold en  long nrep
        rows[0] = '{2, 30, 1'b1, 1'b1, 6};  // long + repeats at +13,+16..+28
        rows[1] = '{2, 30, 1'b0, 1'b1, 0};  // repeat disabled
        rows[2] = '{0,  6, 1'b1, 1'b0, 0};  // short press
        rows[3] = '{3, 10, 1'b1, 1'b0, 0};  // release lands on long threshold
        rows[4] = '{1, 11, 1'b1, 1'b1, 0};  // release before first repeat
        rows[5] = '{0, 16, 1'b1, 1'b1, 1};  // release lands on 2nd repeat tick
        rows[6] = '{1, 20, 1'b1, 1'b1, 3};

        rst_n       = 1'b0;
        i_btn       = 4'hf;
        i_repeat_en = '0;
        rst_n_b     = 1'b0;
        btn_b       = 4'hf;
        rep_en_b    = '0;

        // Reset with all buttons held: outputs stay 0, then one press each.
        repeat (3) at_tick();
        check("reset_outputs", 32'({o_level, o_press, o_release, o_long, o_repeat, o_any_press}), 32'd0);
        k = tick_no;
        for (int c = 0; c < N; c++) push(EV_PRESS, c, k + 4, 2);
        push(EV_ANY, 0, k + 4, 2);
        for (int c = 0; c < N; c++) push(EV_RELEASE, c, k + 9, 2);
        rst_n = 1'b1;
        repeat (4) at_tick();
        check("reset_level_after_debounce", 32'(o_level), 32'hf);
        at_tick();
        i_btn = '0;
        repeat (8) at_tick();
        check_drained("reset_release_events");

        // Table-driven hold scenarios.
        for (int i = 0; i < 7; i++) run_row(i, rows[i]);

        // Bounce on ch0: 1,0,1 on successive ticks, then steady.
        at_tick();
        k = tick_no;
        push(EV_PRESS, 0, k + 6, 2);
        push(EV_ANY, 0, k + 6, 2);
        push(EV_RELEASE, 0, k + 12, 2);
        i_btn[0] = 1'b1;
        at_tick();
        i_btn[0] = 1'b0;
        at_tick();
        i_btn[0] = 1'b1;
        repeat (3) at_tick();
        check("bounce_level_not_yet", 32'(o_level), 32'd0);
        repeat (3) at_tick();
        i_btn[0] = 1'b0;
        repeat (8) at_tick();
        check_drained("bounce_events");

        // ch1 and ch3 pressed in the same clk.
        at_tick();
        k = tick_no;
        push(EV_PRESS, 1, k + 4, 2);
        push(EV_PRESS, 3, k + 4, 2);
        push(EV_ANY, 0, k + 4, 2);
        push(EV_RELEASE, 1, k + 10, 2);
        push(EV_RELEASE, 3, k + 10, 2);
        i_btn = 4'b1010;
        repeat (6) at_tick();
        i_btn = '0;
        repeat (8) at_tick();
        check_drained("simultaneous_events");

        // Repeat enabled partway through HELD on ch2.
        at_tick();
        k = tick_no;
        push(EV_PRESS, 2, k + 4, 2);
        push(EV_ANY, 0, k + 4, 2);
        push(EV_LONG, 2, k + 14, 1);
        for (int j = 0; j < 4; j++) push(EV_REPEAT, 2, k + 23 + 3 * j, 1);
        push(EV_RELEASE, 2, k + 34, 2);
        i_btn[2] = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            at_tick();
            if (t == 20) i_repeat_en[2] = 1'b1;
        end
        i_btn[2] = 1'b0;
        repeat (8) at_tick();
        i_repeat_en = '0;
        check_drained("late_enable_events");

        // Active-low instance.
        check("alow_reset_outputs",
              32'({o_level_b, o_press_b, o_release_b, o_long_b, o_repeat_b, o_any_press_b}), 32'd0);
        rst_n_b = 1'b1;
        repeat (6) at_tick();
        check("alow_level_idle", 32'(o_level_b), 32'd0);
        check("alow_no_spurious_press", 32'(b_press_cnt), 32'd0);
        btn_b[0] = 1'b0;
        repeat (4) at_tick();
        check("alow_level_pressed", 32'(o_level_b), 32'h1);
        check("alow_press_not_early", 32'(o_press_b), 32'd0);
        @(negedge clk);
        check("alow_press_pulse", 32'(o_press_b), 32'h1);
        @(negedge clk);
        check("alow_press_one_clk", 32'(o_press_b), 32'd0);
        repeat (10) at_tick();
        check("alow_long_pulse", 32'(o_long_b), 32'h1);
        repeat (2) at_tick();
        rst_n_b = 1'b0;
        #1;
        check("alow_reset_mid_held",
              32'({o_level_b, o_press_b, o_release_b, o_long_b, o_repeat_b, o_any_press_b}), 32'd0);
        btn_b = 4'hf;
        repeat (2) at_tick();
        rst_n_b = 1'b1;
        repeat (8) at_tick();
        check("alow_no_release", 32'(b_release_cnt), 32'd0);
        check("alow_level_after_reset", 32'(o_level_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
